// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with a pixel clock-enable.
// Sync and blank are delayed to line up with colour returned PIPE pixels later.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_PULSE  = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_PULSE  = 2,
    parameter int V_BACK   = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int CW       = 10,
    parameter int RW       = 3,
    parameter int GW       = 3,
    parameter int BW       = 2,
    parameter int PIPE     = 2,
    parameter int FRAME_W  = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce,
    input  logic [RW+GW+BW-1:0]   color,
    output logic [CW-1:0]         x,
    output logic [CW-1:0]         y,
    output logic                  xy_active,
    output logic                  line_start,
    output logic                  frame_start,
    output logic [FRAME_W-1:0]    frame,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  de,
    output logic [RW-1:0]         red,
    output logic [GW-1:0]         green,
    output logic [BW-1:0]         blue
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_PULSE + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_PULSE + V_BACK;

    localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT     = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT     = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_SYNC_LO = CW'(H_ACTIVE + H_FRONT);
    localparam logic [CW-1:0] H_SYNC_HI = CW'(H_ACTIVE + H_FRONT + H_PULSE - 1);
    localparam logic [CW-1:0] V_SYNC_LO = CW'(V_ACTIVE + V_FRONT);
    localparam logic [CW-1:0] V_SYNC_HI = CW'(V_ACTIVE + V_FRONT + V_PULSE - 1);

    function automatic logic in_window(input logic [CW-1:0] c,
                                       input logic [CW-1:0] lo,
                                       input logic [CW-1:0] hi);
        return (c >= lo) && (c <= hi);
    endfunction

    logic [CW-1:0]      h_p0;
    logic [CW-1:0]      v_p0;
    logic [FRAME_W-1:0] frame_cnt;

    // Stage p0: raster counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_p0      <= '0;
            v_p0      <= '0;
            frame_cnt <= '0;
        end else if (ce) begin
            if (h_p0 < H_LAST) begin
                h_p0 <= h_p0 + CW'(1);
            end else begin
                h_p0 <= '0;
                if (v_p0 < V_LAST) begin
                    v_p0 <= v_p0 + CW'(1);
                end else begin
                    v_p0      <= '0;
                    frame_cnt <= frame_cnt + FRAME_W'(1);
                end
            end
        end
    end

    logic hs_p0, vs_p0, vld_p0;

    assign x           = h_p0;
    assign y           = v_p0;
    assign xy_active   = (h_p0 < H_ACT) && (v_p0 < V_ACT);
    assign line_start  = (h_p0 == '0);
    assign frame_start = (h_p0 == '0) && (v_p0 == '0);
    assign frame       = frame_cnt;

    // Raw sync is active-high here; polarity is applied at the output register.
    assign hs_p0  = in_window(h_p0, H_SYNC_LO, H_SYNC_HI);
    assign vs_p0  = in_window(v_p0, V_SYNC_LO, V_SYNC_HI);
    assign vld_p0 = xy_active;

    logic hs_pd, vs_pd, vld_pd;

    // Stages p1..pPIPE: match the pixel source latency
    generate
        if (PIPE > 0) begin : g_dly
            logic [PIPE-1:0] hs_sr, vs_sr, vld_sr;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    hs_sr  <= '0;
                    vs_sr  <= '0;
                    vld_sr <= '0;
                end else if (ce) begin
                    hs_sr  <= PIPE'({hs_sr, hs_p0});
                    vs_sr  <= PIPE'({vs_sr, vs_p0});
                    vld_sr <= PIPE'({vld_sr, vld_p0});
                end
            end

            assign hs_pd  = hs_sr[PIPE-1];
            assign vs_pd  = vs_sr[PIPE-1];
            assign vld_pd = vld_sr[PIPE-1];
        end else begin : g_nodly
            assign hs_pd  = hs_p0;
            assign vs_pd  = vs_p0;
            assign vld_pd = vld_p0;
        end
    endgenerate

    // Output register: drives the DAC and sync pins directly
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hsync <= ~H_POL;
            vsync <= ~V_POL;
            de    <= 1'b0;
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else if (ce) begin
            hsync <= hs_pd ~^ H_POL;
            vsync <= vs_pd ~^ V_POL;
            de    <= vld_pd;
            {red, green, blue} <= vld_pd ? color : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: two small-raster instances (14x8 total),
// one PIPE=0 active-low with 2-bit frame count, one PIPE=2 active-high.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ce = 1'b0;

    always #5 clk = ~clk;

    logic [3:0] x0, y0, x1, y1;
    logic       xa0, ls0, fs0, xa1, ls1, fs1;
    logic [1:0] frame0;
    logic [10:0] frame1;
    logic       hsync0, vsync0, de0, hsync1, vsync1, de1;
    logic [2:0] red0, green0, red1, green1;
    logic [1:0] blue0, blue1;
    logic [7:0] color0, color1;
    logic [7:0] rgb0, rgb1;
    logic [3:0] src_p1 = 4'h0;
    logic [3:0] src_p2 = 4'h0;

    // dut0 colour source has zero latency; dut1 source is a 2-stage pipe of x
    assign color0 = {4'h5, x0};
    assign color1 = {4'hA, src_p2};
    assign rgb0   = {red0, green0, blue0};
    assign rgb1   = {red1, green1, blue1};

    always @(posedge clk) begin
        if (ce) begin
            src_p1 <= x1;
            src_p2 <= src_p1;
        end
    end

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_PULSE(3), .H_BACK(1),
        .V_ACTIVE(4), .V_FRONT(1), .V_PULSE(2), .V_BACK(1),
        .H_POL(1'b0), .V_POL(1'b0), .CW(4), .RW(3), .GW(3), .BW(2),
        .PIPE(0), .FRAME_W(2)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .color(color0),
        .x(x0), .y(y0), .xy_active(xa0), .line_start(ls0), .frame_start(fs0),
        .frame(frame0), .hsync(hsync0), .vsync(vsync0), .de(de0),
        .red(red0), .green(green0), .blue(blue0)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_PULSE(3), .H_BACK(1),
        .V_ACTIVE(4), .V_FRONT(1), .V_PULSE(2), .V_BACK(1),
        .H_POL(1'b1), .V_POL(1'b1), .CW(4), .RW(3), .GW(3), .BW(2),
        .PIPE(2), .FRAME_W(11)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .color(color1),
        .x(x1), .y(y1), .xy_active(xa1), .line_start(ls1), .frame_start(fs1),
        .frame(frame1), .hsync(hsync1), .vsync(vsync1), .de(de1),
        .red(red1), .green(green1), .blue(blue1)
    );

    int checks = 0;
    int passed = 0;
    int k = 0;  // number of ce edges since the last reset release

    // Hand rules for the 14x8 raster: j is a raster count, negative = before start
    function automatic bit hs_on(input int j);
        return (j >= 0) && ((j % 14) >= 10) && ((j % 14) <= 12);
    endfunction

    function automatic bit vs_on(input int j);
        return (j >= 0) && (((j / 14) % 8) >= 5) && (((j / 14) % 8) <= 6);
    endfunction

    function automatic bit de_on(input int j);
        return (j >= 0) && ((j % 14) < 8) && (((j / 14) % 8) < 4);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ce    = 1'b1;
        step();
        step();
        checks++; if (x0 !== 4'd0 || y0 !== 4'd0) $display("FAIL reset_xy0: got %0d,%0d want 0,0", x0, y0); else passed++;
        checks++; if (frame0 !== 2'd0 || frame1 !== 11'd0) $display("FAIL reset_frame: got %0d,%0d want 0,0", frame0, frame1); else passed++;
        checks++; if (hsync0 !== 1'b1 || vsync0 !== 1'b1) $display("FAIL reset_sync0: got %b%b want 11", hsync0, vsync0); else passed++;
        checks++; if (hsync1 !== 1'b0 || vsync1 !== 1'b0) $display("FAIL reset_sync1: got %b%b want 00", hsync1, vsync1); else passed++;
        checks++; if (de0 !== 1'b0 || de1 !== 1'b0) $display("FAIL reset_de: got %b%b want 00", de0, de1); else passed++;
        checks++; if (rgb0 !== 8'h00 || rgb1 !== 8'h00) $display("FAIL reset_rgb: got %h,%h want 00,00", rgb0, rgb1); else passed++;
        checks++; if (fs0 !== 1'b1 || ls0 !== 1'b1 || xa0 !== 1'b1) $display("FAIL reset_decode: got fs=%b ls=%b xa=%b want 111", fs0, ls0, xa0); else passed++;
        // Released with ce low: nothing may move
        rst_n = 1'b1;
        ce    = 1'b0;
        step();
        step();
        checks++; if (x0 !== 4'd0 || x1 !== 4'd0) $display("FAIL hold_after_reset: got %0d,%0d want 0,0", x0, x1); else passed++;
        k = 0;
    endtask

    // Five frames at ce=1: counters, decodes, syncs, pipe alignment, frame wrap
    task automatic test_raster();
        int j0, j1;
        ce = 1'b1;
        for (int n = 0; n < 5 * 112; n++) begin
            step();
            k++;
            j0 = k - 1;
            j1 = k - 3;
            checks++; if (x0 !== 4'(k % 14) || y0 !== 4'((k / 14) % 8)) $display("FAIL raster_xy k=%0d: got %0d,%0d want %0d,%0d", k, x0, y0, k % 14, (k / 14) % 8); else passed++;
            checks++; if (frame0 !== 2'((k / 112) % 4)) $display("FAIL frame_wrap k=%0d: got %0d want %0d", k, frame0, (k / 112) % 4); else passed++;
            checks++; if (frame1 !== 11'(k / 112)) $display("FAIL frame_count k=%0d: got %0d want %0d", k, frame1, k / 112); else passed++;
            checks++; if (fs0 !== ((k % 112) == 0) || ls0 !== ((k % 14) == 0)) $display("FAIL starts k=%0d: got fs=%b ls=%b", k, fs0, ls0); else passed++;
            checks++; if (xa1 !== de_on(k)) $display("FAIL xy_active k=%0d: got %b want %b", k, xa1, de_on(k)); else passed++;
            checks++; if (hsync0 !== !hs_on(j0) || vsync0 !== !vs_on(j0)) $display("FAIL sync_low k=%0d: got %b%b want %b%b", k, hsync0, vsync0, !hs_on(j0), !vs_on(j0)); else passed++;
            checks++; if (de0 !== de_on(j0) || rgb0 !== (de_on(j0) ? {4'h5, 4'(j0 % 14)} : 8'h00)) $display("FAIL pix0 k=%0d: got de=%b rgb=%h", k, de0, rgb0); else passed++;
            checks++; if (hsync1 !== hs_on(j1) || vsync1 !== vs_on(j1)) $display("FAIL sync_high k=%0d: got %b%b want %b%b", k, hsync1, vsync1, hs_on(j1), vs_on(j1)); else passed++;
            checks++; if (de1 !== de_on(j1) || rgb1 !== (de_on(j1) ? {4'hA, 4'(j1 % 14)} : 8'h00)) $display("FAIL pix1 k=%0d: got de=%b rgb=%h", k, de1, rgb1); else passed++;
        end
    endtask

    // ce high one clock in four: all state steps only on those clocks
    task automatic test_ce_stretch();
        int j1;
        for (int n = 0; n < 80; n++) begin
            ce = ((n % 4) == 0);
            step();
            if (ce) k++;
            j1 = k - 3;
            checks++; if (x0 !== 4'(k % 14) || y0 !== 4'((k / 14) % 8)) $display("FAIL ce_xy n=%0d: got %0d,%0d want %0d,%0d", n, x0, y0, k % 14, (k / 14) % 8); else passed++;
            checks++; if (hsync0 !== !hs_on(k - 1)) $display("FAIL ce_hsync n=%0d: got %b want %b", n, hsync0, !hs_on(k - 1)); else passed++;
            checks++; if (de1 !== de_on(j1) || rgb1 !== (de_on(j1) ? {4'hA, 4'(j1 % 14)} : 8'h00)) $display("FAIL ce_pix1 n=%0d: got de=%b rgb=%h", n, de1, rgb1); else passed++;
        end
    endtask

    // Reset at h=5, v=3 with ce low, then restart
    task automatic test_mid_reset();
        ce = 1'b1;
        for (int n = 0; n < 112 && (k % 112) != 47; n++) begin
            step();
            k++;
        end
        checks++; if (x0 !== 4'd5 || y0 !== 4'd3 || de0 !== 1'b1) $display("FAIL pre_reset_pos: got x=%0d y=%0d de=%b want 5,3,1", x0, y0, de0); else passed++;
        ce    = 1'b0;
        rst_n = 1'b0;
        step();
        checks++; if (x0 !== 4'd0 || y0 !== 4'd0 || x1 !== 4'd0 || y1 !== 4'd0) $display("FAIL mid_reset_xy: got %0d,%0d %0d,%0d want zeros", x0, y0, x1, y1); else passed++;
        checks++; if (frame0 !== 2'd0 || frame1 !== 11'd0) $display("FAIL mid_reset_frame: got %0d,%0d want 0,0", frame0, frame1); else passed++;
        checks++; if (de0 !== 1'b0 || de1 !== 1'b0 || rgb0 !== 8'h00 || rgb1 !== 8'h00) $display("FAIL mid_reset_pix: got de=%b%b rgb=%h,%h want 00 00,00", de0, de1, rgb0, rgb1); else passed++;
        checks++; if (hsync0 !== 1'b1 || vsync0 !== 1'b1 || hsync1 !== 1'b0 || vsync1 !== 1'b0) $display("FAIL mid_reset_sync: got %b%b %b%b want 11 00", hsync0, vsync0, hsync1, vsync1); else passed++;
        rst_n = 1'b1;
        ce    = 1'b1;
        k     = 0;
        checks++; if (fs0 !== 1'b1) $display("FAIL restart_fs: got %b want 1", fs0); else passed++;
        for (int n = 0; n < 4; n++) begin
            step();
            k++;
            checks++; if (x0 !== 4'(k) || y0 !== 4'd0) $display("FAIL restart_xy k=%0d: got %0d,%0d want %0d,0", k, x0, y0, k); else passed++;
            checks++; if (de1 !== de_on(k - 3) || rgb1 !== (de_on(k - 3) ? {4'hA, 4'(k - 3)} : 8'h00)) $display("FAIL restart_pix1 k=%0d: got de=%b rgb=%h", k, de1, rgb1); else passed++;
            checks++; if (de0 !== 1'b1 || rgb0 !== {4'h5, 4'(k - 1)}) $display("FAIL restart_pix0 k=%0d: got de=%b rgb=%h", k, de0, rgb0); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_raster();
        test_ce_stretch();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
